// File: rtl/u_xmit.sv
// u_xmit: UART transmitter, one start bit, WORD_LEN data bits LSB first, STOP_BITS stop bits.
module u_xmit #(
   parameter int BIT_CELL  = 16,
   parameter int WORD_LEN  = 8,
   parameter int STOP_BITS = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rstH,
   input  logic       xmitH,
   input  logic [7:0] xmit_dataH,
   output logic       uart_xmitH,
   output logic       xmit_busyH,
   output logic       xmit_doneH
);
   localparam int CW = (BIT_CELL > 1) ? $clog2(BIT_CELL) : 1;

   typedef enum logic [1:0] {x_IDLE, x_START, x_DATA, x_STOP} state_t;

   state_t        state, stateD;
   logic [CW-1:0] cellCnt, cellCntD;
   logic [3:0]    bitCnt, bitCntD;
   logic [7:0]    shiftReg, shiftRegD;
   logic          lineD;
   logic          cellEnd;

   assign cellEnd    = cellCnt == CW'(BIT_CELL - 1);
   assign xmit_busyH = state != x_IDLE;
   assign xmit_doneH = state == x_STOP && cellEnd && bitCnt == 4'(STOP_BITS - 1);

   always_ff @(posedge sys_clk)
      if (sys_rstH) begin
         state      <= x_IDLE;
         cellCnt    <= '0;
         bitCnt     <= '0;
         shiftReg   <= '0;
         uart_xmitH <= 1'b1;
      end else begin
         state      <= stateD;
         cellCnt    <= cellCntD;
         bitCnt     <= bitCntD;
         shiftReg   <= shiftRegD;
         uart_xmitH <= lineD;
      end

   always_comb begin
      stateD    = state;
      cellCntD  = cellEnd ? '0 : cellCnt + 1'b1;
      bitCntD   = bitCnt;
      shiftRegD = shiftReg;
      case (state)
         x_IDLE: begin
            cellCntD = '0;
            if (xmitH) begin
               stateD    = x_START;
               shiftRegD = xmit_dataH;
            end
         end
         x_START: if (cellEnd) begin
            stateD  = x_DATA;
            bitCntD = '0;
         end
         x_DATA: if (cellEnd) begin
            shiftRegD = shiftReg >> 1;
            bitCntD   = bitCnt == 4'(WORD_LEN - 1) ? '0 : bitCnt + 4'd1;
            stateD    = bitCnt == 4'(WORD_LEN - 1) ? x_STOP : x_DATA;
         end
         x_STOP: if (cellEnd) begin
            bitCntD = bitCnt == 4'(STOP_BITS - 1) ? '0 : bitCnt + 4'd1;
            stateD  = bitCnt == 4'(STOP_BITS - 1) ? x_IDLE : x_STOP;
         end
         default: stateD = x_IDLE;
      endcase
      // Line level is chosen from the next state so it leaves a flop glitch-free.
      lineD = (stateD == x_START) ? 1'b0 : (stateD == x_DATA) ? shiftRegD[0] : 1'b1;
   end
endmodule

// File: tb/tb_u_xmit.sv
// tb_u_xmit: frame-timing model plus mid-cell line decoder checked against u_xmit every cycle.
module tb_u_xmit;
   localparam int BC    = 16;
   localparam int WL    = 8;
   localparam int SB    = 1;
   localparam int FRAME = (1 + WL + SB) * BC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       xmitH = 1'b0;
   logic [7:0] xmitData = 8'h00;
   logic       lineOut, busyOut, doneOut;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   bit         chkEn = 0;
   bit         active = 0;
   int         mT = 0;
   logic [7:0] mData = 8'h00;
   int         doneQ[$];
   logic [7:0] rxQ[$];
   bit         rxIn = 0;
   int         rxCnt = 0;
   logic [7:0] rxByte = 8'h00;

   u_xmit #(.BIT_CELL(BC), .WORD_LEN(WL), .STOP_BITS(SB)) dut (
      .sys_clk(clk), .sys_rstH(rst), .xmitH(xmitH), .xmit_dataH(xmitData),
      .uart_xmitH(lineOut), .xmit_busyH(busyOut), .xmit_doneH(doneOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   // Model: a frame accepted in cycle mT occupies cycles mT+1 .. mT+FRAME.
   always @(posedge clk) begin
      bit wasRst;
      int off;
      logic eLine;
      wasRst = rst;
      off = cyc - mT;
      if (rst) begin
         active = 0;
         chkEn  = 1;
      end else if (xmitH && !(active && off >= 1 && off <= FRAME)) begin
         active = 1;
         mT     = cyc;
         mData  = xmitData;
      end
      cyc++;
      #1;
      if (chkEn) begin
         off = cyc - mT;
         if (!active || off < 1 || off > FRAME) eLine = 1'b1;
         else if (off <= BC) eLine = 1'b0;
         else if (off <= (1 + WL) * BC) eLine = mData[(off - 1) / BC - 1];
         else eLine = 1'b1;
         chk("line", lineOut, eLine);
         chk("busy", busyOut, active && off >= 1 && off <= FRAME);
         chk("done", doneOut, active && off == FRAME);
         if (doneOut) doneQ.push_back(cyc);
         if (wasRst) rxIn = 0;
         else if (!rxIn) begin
            if (lineOut == 1'b0) begin
               rxIn  = 1;
               rxCnt = 0;
            end
         end else begin
            rxCnt++;
            if (rxCnt >= 24 && rxCnt < 152 && rxCnt % 16 == 8) rxByte[(rxCnt - 24) / 16] = lineOut;
            if (rxCnt == 152) begin
               chk("stopbit", lineOut, 1);
               rxQ.push_back(rxByte);
               rxIn = 0;
            end
         end
      end
   end

   task automatic waitTo(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, output int t);
      xmitH    = 1'b1;
      xmitData = d;
      t        = cyc;
      @(negedge clk);
      xmitH    = 1'b0;
      xmitData = ~d;
   endtask

   task automatic expectRx(input string name, input logic [7:0] d);
      chk({name, "_cnt"}, rxQ.size(), 1);
      if (rxQ.size() > 0) chk(name, rxQ.pop_front(), d);
      rxQ.delete();
   endtask

   initial begin
      int t, n, s;
      logic [9:0] got;
      logic [7:0] bytes[3];
      repeat (3) @(negedge clk);
      rst = 1'b0;
      s = cyc;
      waitTo(s + 50);
      chk("idle_line", lineOut, 1);
      chk("idle_done_cnt", doneQ.size(), 0);

      send(8'hA5, t);
      for (int i = 0; i < 10; i++) begin
         waitTo(t + 9 + 16 * i);
         got[i] = lineOut;
      end
      chk("a5_bits", got, 10'b1101001010);
      waitTo(t + 161);
      chk("a5_busy_end", busyOut, 0);
      chk("a5_done_at", doneQ.size() > 0 ? doneQ[doneQ.size() - 1] - t : -1, 160);
      expectRx("a5_rx", 8'hA5);

      send(8'h3C, t);
      n = doneQ.size();
      waitTo(t + 40);
      xmitH = 1'b1; xmitData = 8'hFF;
      @(negedge clk);
      xmitH = 1'b0;
      waitTo(t + 160);
      xmitH = 1'b1; xmitData = 8'hFF;
      @(negedge clk);
      xmitH = 1'b0;
      waitTo(t + 200);
      chk("3c_done_cnt", doneQ.size() - n, 1);
      expectRx("3c_rx", 8'h3C);

      xmitH = 1'b1; xmitData = 8'h00; t = cyc;
      n = doneQ.size();
      waitTo(t + 100);
      xmitData = 8'hFF;
      waitTo(t + 161);
      chk("b2b_gap_line", lineOut, 1);
      waitTo(t + 162);
      chk("b2b_start2", lineOut, 0);
      waitTo(t + 170);
      xmitH = 1'b0;
      waitTo(t + 340);
      chk("b2b_done_cnt", doneQ.size() - n, 2);
      if (doneQ.size() - n == 2) chk("b2b_spacing", doneQ[n + 1] - doneQ[n], 161);
      chk("b2b_rx_cnt", rxQ.size(), 2);
      if (rxQ.size() == 2) begin
         chk("b2b_rx0", rxQ[0], 8'h00);
         chk("b2b_rx1", rxQ[1], 8'hFF);
      end
      rxQ.delete();

      send(8'h55, t);
      n = doneQ.size();
      waitTo(t + 70);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_line", lineOut, 1);
      chk("rst_busy", busyOut, 0);
      waitTo(t + 250);
      chk("rst_no_done", doneQ.size() - n, 0);
      chk("rst_no_rx", rxQ.size(), 0);
      rst = 1'b1; xmitH = 1'b1; xmitData = 8'h77;
      @(negedge clk);
      rst = 1'b0; xmitH = 1'b0;
      @(negedge clk);
      chk("rst_req_drop", busyOut, 0);
      send(8'hC3, t);
      waitTo(t + 170);
      expectRx("post_rst_rx", 8'hC3);

      bytes = '{8'h00, 8'h81, 8'hFF};
      foreach (bytes[i]) begin
         send(bytes[i], t);
         waitTo(t + 170);
         expectRx("loop_rx", bytes[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
